// File: rtl/reg_bank.sv
// reg_bank: NREG x DATA_W register file with one write port and two
// registered read ports (D and S) sharing a single read-request strobe.
//
// Optional feature macro: REG_BYPASS_EN
//   defined   -> a read port whose address matches a same-cycle write
//                returns wdata (write-through, no extra latency).
//   undefined -> that port returns the pre-write register contents; the
//                new value is visible from the following read cycle.
//
// Read strobe semantics: en_in is a valid-only request with no back-pressure;
// every cycle with en_in=1 yields exactly one result one cycle later with
// en_out=1, and every cycle with en_in=0 yields en_out=0 and zeroed data.
module reg_bank #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              en_in,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs,
  output logic              en_out,
  output logic [DATA_W-1:0] rd_q,
  output logic [DATA_W-1:0] rs_q
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic              en_out_q, en_out_d;
  logic [DATA_W-1:0] rd_q_q, rd_q_d;
  logic [DATA_W-1:0] rs_q_q, rs_q_d;

  // Storage next-state: only the addressed register takes wdata when we=1.
  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[waddr] = wdata;
    end
  end

  // Read next-state: data is zero whenever no read is requested.
  always_comb begin
    en_out_d = 1'b0;
    rd_q_d   = '0;
    rs_q_d   = '0;
    if (en_in) begin
      en_out_d = 1'b1;
      rd_q_d   = regs_q[rd];
      rs_q_d   = regs_q[rs];
`ifdef REG_BYPASS_EN
      // Forward the in-flight write to any port reading the same address.
      if (we && (rd == waddr)) begin
        rd_q_d = wdata;
      end
      if (we && (rs == waddr)) begin
        rs_q_d = wdata;
      end
`endif
    end
  end

  // State registers; reset wins over any write or read in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      en_out_q <= 1'b0;
      rd_q_q   <= '0;
      rs_q_q   <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      en_out_q <= en_out_d;
      rd_q_q   <= rd_q_d;
      rs_q_q   <= rs_q_d;
    end
  end

  assign en_out = en_out_q;
  assign rd_q   = rd_q_q;
  assign rs_q   = rs_q_q;

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed tests for reg_bank at default parameters plus a
// DATA_W=32 / ADDR_W=4 instance for the parameter sweep.
module tb_reg_bank;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // default instance
  logic        rst, we, en_in;
  logic [1:0]  waddr, rd, rs;
  logic [15:0] wdata;
  logic        en_out;
  logic [15:0] rd_q, rs_q;

  // wide instance
  logic        rst_w, we_w, en_in_w;
  logic [3:0]  waddr_w, rd_w, rs_w;
  logic [31:0] wdata_w;
  logic        en_out_w;
  logic [31:0] rd_q_w, rs_q_w;

  reg_bank #(.DATA_W(16), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .en_in(en_in), .rd(rd), .rs(rs),
    .en_out(en_out), .rd_q(rd_q), .rs_q(rs_q)
  );

  reg_bank #(.DATA_W(32), .ADDR_W(4)) dut_w (
    .clk(clk), .rst(rst_w), .we(we_w), .waddr(waddr_w), .wdata(wdata_w),
    .en_in(en_in_w), .rd(rd_w), .rs(rs_w),
    .en_out(en_out_w), .rd_q(rd_q_w), .rs_q(rs_q_w)
  );

  // ---------------- driver tasks ----------------
  // Advance one rising edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    en_in = 1'b0; rd = '0; rs = '0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [15:0] d);
    idle();
    we = 1'b1; waddr = a; wdata = d;
    tick();
    idle();
  endtask

  task automatic do_read(input logic [1:0] a_d, input logic [1:0] a_s);
    idle();
    en_in = 1'b1; rd = a_d; rs = a_s;
    tick();
    idle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    total++; if (en_out !== 1'b0) begin bad++; $display("FAIL reset_en_out got=%b exp=0", en_out); end
    total++; if (rd_q !== 16'h0) begin bad++; $display("FAIL reset_rd_q got=%h exp=0000", rd_q); end
    total++; if (rs_q !== 16'h0) begin bad++; $display("FAIL reset_rs_q got=%h exp=0000", rs_q); end
    do_read(2'd0, 2'd3);
    total++; if (en_out !== 1'b1) begin bad++; $display("FAIL reset_read_en got=%b exp=1", en_out); end
    total++; if (rd_q !== 16'h0000) begin bad++; $display("FAIL reset_read_rd got=%h exp=0000", rd_q); end
    total++; if (rs_q !== 16'h0000) begin bad++; $display("FAIL reset_read_rs got=%h exp=0000", rs_q); end
  endtask

  task automatic test_write_read();
    do_write(2'd2, 16'hA5C3);
    do_read(2'd2, 2'd2);
    total++; if (en_out !== 1'b1) begin bad++; $display("FAIL wr_en got=%b exp=1", en_out); end
    total++; if (rd_q !== 16'hA5C3) begin bad++; $display("FAIL wr_rd got=%h exp=a5c3", rd_q); end
    total++; if (rs_q !== 16'hA5C3) begin bad++; $display("FAIL wr_rs got=%h exp=a5c3", rs_q); end
    do_read(2'd0, 2'd1);
    total++; if (rd_q !== 16'h0) begin bad++; $display("FAIL wr_other0 got=%h exp=0000", rd_q); end
    total++; if (rs_q !== 16'h0) begin bad++; $display("FAIL wr_other1 got=%h exp=0000", rs_q); end
    do_read(2'd3, 2'd3);
    total++; if (rd_q !== 16'h0) begin bad++; $display("FAIL wr_other3 got=%h exp=0000", rd_q); end
  endtask

  task automatic test_hazard();
    logic [15:0] exp_rd;
`ifdef REG_BYPASS_EN
    exp_rd = 16'h2222;
`else
    exp_rd = 16'h1111;
`endif
    do_write(2'd1, 16'h1111);
    idle();
    we = 1'b1; waddr = 2'd1; wdata = 16'h2222;
    en_in = 1'b1; rd = 2'd1; rs = 2'd0;
    tick();
    idle();
    total++; if (en_out !== 1'b1) begin bad++; $display("FAIL hazard_en got=%b exp=1", en_out); end
    total++; if (rd_q !== exp_rd) begin bad++; $display("FAIL hazard_rd got=%h exp=%h", rd_q, exp_rd); end
    total++; if (rs_q !== 16'h0000) begin bad++; $display("FAIL hazard_rs got=%h exp=0000", rs_q); end
    // rs side of the hazard: port S matches the write address
    idle();
    we = 1'b1; waddr = 2'd0; wdata = 16'h1234;
    en_in = 1'b1; rd = 2'd1; rs = 2'd0;
    tick();
    idle();
`ifdef REG_BYPASS_EN
    total++; if (rs_q !== 16'h1234) begin bad++; $display("FAIL hazard_rs_fwd got=%h exp=1234", rs_q); end
`else
    total++; if (rs_q !== 16'h0000) begin bad++; $display("FAIL hazard_rs_fwd got=%h exp=0000", rs_q); end
`endif
    total++; if (rd_q !== 16'h2222) begin bad++; $display("FAIL hazard_rd_new got=%h exp=2222", rd_q); end
  endtask

  // Registers now: 0=1234 1=2222 2=a5c3 3=0000
  task automatic test_back_to_back();
    logic [15:0] exp_q [$];
    logic [15:0] exp_s [$];
    logic [15:0] e, es;
    exp_q.push_back(16'h1234); exp_s.push_back(16'h0000);
    exp_q.push_back(16'h2222); exp_s.push_back(16'hA5C3);
    exp_q.push_back(16'hA5C3); exp_s.push_back(16'h2222);
    idle();
    en_in = 1'b1; rd = 2'd0; rs = 2'd3;
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin rd = 2'd1; rs = 2'd2; end
      else if (i == 1) begin rd = 2'd2; rs = 2'd1; end
      else begin en_in = 1'b0; rd = 2'd0; rs = 2'd0; end
      e = exp_q.pop_front();
      es = exp_s.pop_front();
      total++; if (en_out !== 1'b1) begin bad++; $display("FAIL stream_en[%0d] got=%b exp=1", i, en_out); end
      total++; if (rd_q !== e) begin bad++; $display("FAIL stream_rd[%0d] got=%h exp=%h", i, rd_q, e); end
      total++; if (rs_q !== es) begin bad++; $display("FAIL stream_rs[%0d] got=%h exp=%h", i, rs_q, es); end
      tick();
    end
    total++; if (en_out !== 1'b0) begin bad++; $display("FAIL idle_en got=%b exp=0", en_out); end
    total++; if (rd_q !== 16'h0) begin bad++; $display("FAIL idle_rd got=%h exp=0000", rd_q); end
    total++; if (rs_q !== 16'h0) begin bad++; $display("FAIL idle_rs got=%h exp=0000", rs_q); end
    idle();
  endtask

  task automatic test_reset_priority();
    idle();
    rst = 1'b1; we = 1'b1; waddr = 2'd3; wdata = 16'hFFFF;
    en_in = 1'b1; rd = 2'd2; rs = 2'd1;
    tick();
    idle();
    total++; if (en_out !== 1'b0) begin bad++; $display("FAIL rstpri_en got=%b exp=0", en_out); end
    total++; if (rd_q !== 16'h0) begin bad++; $display("FAIL rstpri_rd got=%h exp=0000", rd_q); end
    do_read(2'd3, 2'd2);
    total++; if (rd_q !== 16'h0000) begin bad++; $display("FAIL rstpri_r3 got=%h exp=0000", rd_q); end
    total++; if (rs_q !== 16'h0000) begin bad++; $display("FAIL rstpri_r2 got=%h exp=0000", rs_q); end
  endtask

  task automatic test_midstream_reset();
    do_write(2'd1, 16'h8001);
    idle();
    en_in = 1'b1; rd = 2'd1; rs = 2'd1;
    tick();
    total++; if (rd_q !== 16'h8001) begin bad++; $display("FAIL mid_pre got=%h exp=8001", rd_q); end
    rst = 1'b1;
    tick();
    rst = 1'b0; en_in = 1'b0;
    total++; if (en_out !== 1'b0) begin bad++; $display("FAIL mid_en got=%b exp=0", en_out); end
    total++; if (rd_q !== 16'h0) begin bad++; $display("FAIL mid_rd got=%h exp=0000", rd_q); end
    do_read(2'd1, 2'd0);
    total++; if (rd_q !== 16'h0000) begin bad++; $display("FAIL mid_cleared got=%h exp=0000", rd_q); end
  endtask

  task automatic test_full_width();
    do_write(2'd3, 16'hFFFF);
    do_write(2'd0, 16'h8000);
    do_read(2'd3, 2'd0);
    total++; if (rd_q !== 16'hFFFF) begin bad++; $display("FAIL width_ffff got=%h exp=ffff", rd_q); end
    total++; if (rs_q !== 16'h8000) begin bad++; $display("FAIL width_8000 got=%h exp=8000", rs_q); end
  endtask

  task automatic test_param_sweep();
    rst_w = 1'b1; we_w = 1'b0; en_in_w = 1'b0;
    waddr_w = '0; wdata_w = '0; rd_w = '0; rs_w = '0;
    tick();
    rst_w = 1'b0; we_w = 1'b1; waddr_w = 4'd15; wdata_w = 32'hDEADBEEF;
    tick();
    we_w = 1'b0; en_in_w = 1'b1; rd_w = 4'd15; rs_w = 4'd0;
    tick();
    en_in_w = 1'b0;
    total++; if (en_out_w !== 1'b1) begin bad++; $display("FAIL sweep_en got=%b exp=1", en_out_w); end
    total++; if (rd_q_w !== 32'hDEADBEEF) begin bad++; $display("FAIL sweep_rd got=%h exp=deadbeef", rd_q_w); end
    total++; if (rs_q_w !== 32'h00000000) begin bad++; $display("FAIL sweep_rs got=%h exp=00000000", rs_q_w); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle();
    rst = 1'b1;
    rst_w = 1'b1; we_w = 1'b0; en_in_w = 1'b0;
    waddr_w = '0; wdata_w = '0; rd_w = '0; rs_w = '0;
    #1;
    test_reset();
    test_write_read();
    test_hazard();
    test_back_to_back();
    test_reset_priority();
    test_midstream_reset();
    test_full_width();
    test_param_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
